// File: rtl/glitch_seq_pkg.sv
// Shared constants for the glitch sequencer: register map, CTRL bit positions,
// FSM state encoding and the hard upper bound on pulse slots.
package glitch_seq_pkg;

  localparam int unsigned MAX_PULSES = 8;

  // Register addresses
  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_NPULSE    = 6'h01;
  localparam logic [5:0] ADDR_SHOTS     = 6'h02;
  localparam logic [5:0] ADDR_SLOT_BASE = 6'h08;

  // CTRL write bits
  localparam int unsigned CTRL_ARM     = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_SW_TRIG = 2;
  localparam int unsigned CTRL_REARM   = 3;

  // CTRL read bits
  localparam int unsigned STAT_READY = 0;
  localparam int unsigned STAT_ARMED = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_DONE  = 3;
  localparam int unsigned STAT_REARM = 4;

  typedef enum logic [1:0] {StIdle, StArmed, StDelay, StPulse} state_e;

endpackage

// File: rtl/glitch_seq_core.sv
// Sequencer core: trigger synchroniser and edge detect, FSM, delay/width
// counters and slot index. Optional auto-rearm and shot counter are built
// when GLITCH_SEQ_AUTOREARM_EN is defined.
module glitch_seq_core
  import glitch_seq_pkg::*;
#(
  parameter int unsigned NUM_PULSES = 4,
  parameter int unsigned DELAY_W    = 16,
  parameter int unsigned WIDTH_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trig,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          sw_trig,
  input  logic [3:0]                    npulse,
  input  logic [NUM_PULSES*DELAY_W-1:0] delay_flat,
  input  logic [NUM_PULSES*WIDTH_W-1:0] width_flat,
`ifdef GLITCH_SEQ_AUTOREARM_EN
  input  logic                          autorearm,
  output logic [7:0]                    shots,
`endif
  output state_e                        state,
  output logic                          done,
  output logic                          glitch
);

  logic [1:0]         sync_q;
  logic               trig_prev_q;
  logic               trig_edge;
  logic [2:0]         k_q;
  logic [DELAY_W-1:0] dcnt_q;
  logic [WIDTH_W-1:0] wcnt_q;

  logic [DELAY_W-1:0] delay_arr [MAX_PULSES];
  logic [WIDTH_W-1:0] width_arr [MAX_PULSES];

  // Unused slots above NUM_PULSES read as zero so a 3-bit index is always legal
  for (genvar g = 0; g < MAX_PULSES; g++) begin : g_slot
    if (g < NUM_PULSES) begin : g_used
      assign delay_arr[g] = delay_flat[g*DELAY_W +: DELAY_W];
      assign width_arr[g] = width_flat[g*WIDTH_W +: WIDTH_W];
    end else begin : g_unused
      assign delay_arr[g] = '0;
      assign width_arr[g] = '0;
    end
  end

  assign trig_edge = sync_q[1] & ~trig_prev_q;

  logic [3:0]         npulse_eff;
  logic [3:0]         k_next;
  logic               more;
  logic [WIDTH_W-1:0] cur_width;
  logic [DELAY_W-1:0] nxt_delay;
  logic [WIDTH_W-1:0] nxt_width;

  assign npulse_eff = (npulse == 4'd0) ? 4'd1 : npulse;
  assign k_next     = {1'b0, k_q} + 4'd1;
  assign more       = k_next < npulse_eff;
  assign cur_width  = width_arr[k_q];
  assign nxt_delay  = delay_arr[k_next[2:0]];
  assign nxt_width  = width_arr[k_next[2:0]];

  state_e             adv_state;
  logic [DELAY_W-1:0] adv_dcnt;
  logic [WIDTH_W-1:0] adv_wcnt;
  logic               adv_glitch;
  logic               adv_finish;

  // Next values when a slot ends; a zero delay chains straight into the next pulse
  always_comb begin
    adv_state  = StDelay;
    adv_dcnt   = '0;
    adv_wcnt   = '0;
    adv_glitch = 1'b0;
    adv_finish = 1'b0;
    if (!more) begin
      adv_finish = 1'b1;
`ifdef GLITCH_SEQ_AUTOREARM_EN
      adv_state  = autorearm ? StArmed : StIdle;
`else
      adv_state  = StIdle;
`endif
    end else if (nxt_delay == '0) begin
      if (nxt_width != '0) begin
        adv_state  = StPulse;
        adv_wcnt   = nxt_width - WIDTH_W'(1);
        adv_glitch = 1'b1;
      end
    end else begin
      // The edge that ends a pulse already counts as the first delay cycle
      adv_dcnt = nxt_delay - DELAY_W'(1);
    end
  end

  // Trigger synchroniser, sequencer FSM and registered glitch output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      state       <= StIdle;
      k_q         <= '0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      glitch      <= 1'b0;
      done        <= 1'b0;
`ifdef GLITCH_SEQ_AUTOREARM_EN
      shots       <= '0;
`endif
    end else begin
      sync_q      <= {sync_q[0], trig};
      trig_prev_q <= sync_q[1];
      if (abort) begin
        state  <= StIdle;
        glitch <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (arm) begin
              state <= StArmed;
              done  <= 1'b0;
`ifdef GLITCH_SEQ_AUTOREARM_EN
              shots <= '0;
`endif
            end
          end
          StArmed: begin
            if (trig_edge || sw_trig) begin
              state  <= StDelay;
              k_q    <= '0;
              dcnt_q <= delay_arr[0];
            end
          end
          StDelay, StPulse: begin
            if (state == StDelay && dcnt_q != '0) begin
              dcnt_q <= dcnt_q - DELAY_W'(1);
            end else if (state == StDelay && cur_width != '0) begin
              state  <= StPulse;
              wcnt_q <= cur_width - WIDTH_W'(1);
              glitch <= 1'b1;
            end else if (state == StPulse && wcnt_q != '0) begin
              wcnt_q <= wcnt_q - WIDTH_W'(1);
            end else begin
              state  <= adv_state;
              dcnt_q <= adv_dcnt;
              wcnt_q <= adv_wcnt;
              glitch <= adv_glitch;
              k_q    <= k_next[2:0];
              if (adv_finish) begin
                done <= 1'b1;
`ifdef GLITCH_SEQ_AUTOREARM_EN
                if (shots != 8'hFF) shots <= shots + 8'd1;
`endif
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/glitch_seq_wb.sv
// Wishbone glitch sequencer top: register file, bus handshake and read mux
// around glitch_seq_core. Define GLITCH_SEQ_AUTOREARM_EN for auto-rearm and
// the shot counter at 0x02.
module glitch_seq_wb
  import glitch_seq_pkg::*;
#(
  parameter int unsigned NUM_PULSES = 4,
  parameter int unsigned DELAY_W    = 16,
  parameter int unsigned WIDTH_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [5:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic       trig_i,
  output logic       glitch_o,
  output logic       busy_o
);

  logic [3:0]         npulse_q;
  logic [DELAY_W-1:0] delay_q [NUM_PULSES];
  logic [WIDTH_W-1:0] width_q [NUM_PULSES];
  logic [15:0]        dly_ext [NUM_PULSES];
  logic [NUM_PULSES*DELAY_W-1:0] delay_flat;
  logic [NUM_PULSES*WIDTH_W-1:0] width_flat;

  state_e     core_state;
  logic       core_done;
  logic [7:0] shots;
  logic       rearm_q;

  for (genvar g = 0; g < NUM_PULSES; g++) begin : g_flat
    assign delay_flat[g*DELAY_W +: DELAY_W] = delay_q[g];
    assign width_flat[g*WIDTH_W +: WIDTH_W] = width_q[g];
    assign dly_ext[g] = 16'(delay_q[g]);
  end

  logic       wr_en;
  logic       ctrl_wr;
  logic       slot_hit;
  logic [3:0] slot_idx;

  // Only the first cycle of a strobe counts; the acked cycle is idle
  assign wr_en    = stb_i & we_i & ~ack_o;
  assign ctrl_wr  = wr_en && (adr_i == ADDR_CTRL);
  assign slot_idx = adr_i[5:2] - 4'd2;
  assign slot_hit = (adr_i >= ADDR_SLOT_BASE) && (slot_idx < 4'(NUM_PULSES));
  assign busy_o   = (core_state != StIdle);

  logic [7:0] rd_data;

  // Read mux, sampled into dat_o on the acking edge
  always_comb begin
    rd_data = 8'h00;
    if (adr_i == ADDR_CTRL) begin
      rd_data[STAT_READY] = (core_state == StIdle);
      rd_data[STAT_ARMED] = (core_state == StArmed);
      rd_data[STAT_BUSY]  = (core_state != StIdle);
      rd_data[STAT_DONE]  = core_done;
      rd_data[STAT_REARM] = rearm_q;
    end else if (adr_i == ADDR_NPULSE) begin
      rd_data = {4'b0000, npulse_q};
    end else if (adr_i == ADDR_SHOTS) begin
      rd_data = shots;
    end else begin
      for (int i = 0; i < NUM_PULSES; i++) begin
        if (slot_hit && slot_idx == 4'(i)) begin
          unique case (adr_i[1:0])
            2'd0:    rd_data = dly_ext[i][7:0];
            2'd1:    rd_data = dly_ext[i][15:8];
            2'd2:    rd_data = 8'(width_q[i]);
            default: rd_data = 8'h00;
          endcase
        end
      end
    end
  end

  // Bus handshake and config register writes (config locked outside IDLE)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= 8'h00;
      npulse_q <= '0;
      for (int i = 0; i < NUM_PULSES; i++) begin
        delay_q[i] <= '0;
        width_q[i] <= '0;
      end
    end else begin
      ack_o <= stb_i & ~ack_o;
      dat_o <= (stb_i && !ack_o && !we_i) ? rd_data : 8'h00;
      if (wr_en && core_state == StIdle) begin
        if (adr_i == ADDR_NPULSE) begin
          npulse_q <= (dat_i[3:0] > 4'(NUM_PULSES)) ? 4'(NUM_PULSES) : dat_i[3:0];
        end
        for (int i = 0; i < NUM_PULSES; i++) begin
          if (slot_hit && slot_idx == 4'(i)) begin
            unique case (adr_i[1:0])
              2'd0:    delay_q[i] <= DELAY_W'({dly_ext[i][15:8], dat_i});
              2'd1:    delay_q[i] <= DELAY_W'({dat_i, dly_ext[i][7:0]});
              2'd2:    width_q[i] <= dat_i[WIDTH_W-1:0];
              default: ;
            endcase
          end
        end
      end
    end
  end

`ifdef GLITCH_SEQ_AUTOREARM_EN
  // Auto-rearm flag follows CTRL bit3 on every CTRL write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rearm_q <= 1'b0;
    end else if (ctrl_wr) begin
      rearm_q <= dat_i[CTRL_REARM];
    end
  end
`else
  assign rearm_q = 1'b0;
  assign shots   = 8'h00;
`endif

  glitch_seq_core #(
    .NUM_PULSES (NUM_PULSES),
    .DELAY_W    (DELAY_W),
    .WIDTH_W    (WIDTH_W)
  ) u_core (
    .clk        (clk_i),
    .rst        (rst_i),
    .trig       (trig_i),
    .arm        (ctrl_wr & dat_i[CTRL_ARM]),
    .abort      (ctrl_wr & dat_i[CTRL_ABORT]),
    .sw_trig    (ctrl_wr & dat_i[CTRL_SW_TRIG]),
    .npulse     (npulse_q),
    .delay_flat (delay_flat),
    .width_flat (width_flat),
`ifdef GLITCH_SEQ_AUTOREARM_EN
    .autorearm  (rearm_q),
    .shots      (shots),
`endif
    .state      (core_state),
    .done       (core_done),
    .glitch     (glitch_o)
  );

endmodule
